alu_logic_serial: RTL and testbench

Multi-cycle, handshaked bitwise logic unit for the ALU. It accepts two operands and an op code on a valid/ready input channel. It evaluates AND/OR/XOR/ANDN over CHUNK bits per cycle, least-significant chunk first, and returns the assembled word plus a zero flag on a valid/ready output channel. It sits between the operand-issue stage and the writeback mux as the area-reduced alternative to the fully parallel per-bit gate operation modules.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_logic_slice.sv | 25 ++
 rtl/alu_logic_serial.sv | 108 ++++++++++
 tb/tb_alu_logic_serial.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-unit op codes and the serial logic unit state type.
package alu_pkg;

  localparam logic [1:0] ALU_LOG_AND  = 2'b00;
  localparam logic [1:0] ALU_LOG_OR   = 2'b01;
  localparam logic [1:0] ALU_LOG_XOR  = 2'b10;
  localparam logic [1:0] ALU_LOG_ANDN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } alu_log_state_e;

endpackage

// File: rtl/alu_logic_slice.sv
// Combinational CHUNK-bit bitwise operation; the single point of op decoding.
module alu_logic_slice
  import alu_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [1:0]       op,
  output logic [CHUNK-1:0] y
);

  // Select the bitwise function for this chunk
  always_comb begin
    y = {CHUNK{1'b0}};
    case (op)
      ALU_LOG_AND:  y = a & b;
      ALU_LOG_OR:   y = a | b;
      ALU_LOG_XOR:  y = a ^ b;
      ALU_LOG_ANDN: y = a & ~b;
      default:      y = {CHUNK{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_logic_serial.sv
// Serial bitwise logic unit: evaluates CHUNK bits per cycle, LS chunk first,
// with valid/ready on both sides and a synchronous flush.
module alu_logic_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  alu_log_state_e   state_r, state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r, b_r, res_r;
  logic [1:0]       op_r;
  logic             zero_r;

  logic             accept_s, run_s, last_s;
  logic [CHUNK-1:0] y_s;
  logic [WIDTH-1:0] y_ext_s, res_s;

  assign in_ready   = (state_r == ST_IDLE) && !flush;
  assign out_valid  = (state_r == ST_DONE);
  assign out_result = res_r;
  assign out_zero   = zero_r;

  assign accept_s = in_valid && in_ready;
  assign run_s    = (state_r == ST_RUN);
  assign last_s   = run_s && (cnt_r == CW'(NCHUNK - 1));

  alu_logic_slice #(.CHUNK(CHUNK)) u_slice (
    .a  (a_r[CHUNK-1:0]),
    .b  (b_r[CHUNK-1:0]),
    .op (op_r),
    .y  (y_s)
  );

  // New chunk enters at the MSB so the first chunk lands at bits [CHUNK-1:0]
  assign y_ext_s = WIDTH'(y_s);
  assign res_s   = (y_ext_s << (WIDTH - CHUNK)) | (res_r >> CHUNK);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic; flush overrides both handshakes
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: if (in_valid)  state_s = ST_RUN;  else state_s = ST_IDLE;
        ST_RUN:  if (last_s)    state_s = ST_DONE; else state_s = ST_RUN;
        ST_DONE: if (out_ready) state_s = ST_IDLE; else state_s = ST_DONE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Operand capture, chunk shifting, counter and zero flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CW{1'b0}};
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      op_r   <= 2'b00;
      res_r  <= {WIDTH{1'b0}};
      zero_r <= 1'b0;
    end else if (flush) begin
      cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      a_r   <= in_a;
      b_r   <= in_b;
      op_r  <= in_op;
      cnt_r <= {CW{1'b0}};
    end else if (run_s) begin
      a_r   <= a_r >> CHUNK;
      b_r   <= b_r >> CHUNK;
      res_r <= res_s;
      if (last_s) begin
        cnt_r  <= {CW{1'b0}};
        zero_r <= (res_s == {WIDTH{1'b0}});
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_alu_logic_serial.sv
// Randomised and directed bench for alu_logic_serial at CHUNK = 1, 8 and 32.
module tb_alu_logic_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  iv = 3'b000;
  logic [2:0]  ir, ov, zr;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_a = 32'h0, in_b = 32'h0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] res [3];

  int n_tests = 0;
  int n_fail  = 0;
  int nchunk [3] = '{32, 4, 1};

  always #5 clk = ~clk;

  alu_logic_serial #(.WIDTH(32), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(ov[0]), .out_ready(out_ready),
    .out_result(res[0]), .out_zero(zr[0]));
  alu_logic_serial #(.WIDTH(32), .CHUNK(8)) u_c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(ov[1]), .out_ready(out_ready),
    .out_result(res[1]), .out_zero(zr[1]));
  alu_logic_serial #(.WIDTH(32), .CHUNK(32)) u_c32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .flush(flush), .out_valid(ov[2]), .out_ready(out_ready),
    .out_result(res[2]), .out_zero(zr[2]));

  // Word-level reference: op codes 00 AND, 01 OR, 10 XOR, 11 A & ~B
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Offer a request on instance k and wait for out_valid; returns cycles after accept.
  // Called and returns just after a falling edge.
  task automatic issue_wait(input int k, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, output int lat);
    int g;
    in_op = op; in_a = a; in_b = b; iv[k] = 1'b1;
    #1;
    g = 0;
    while (!ir[k] && g < 200) begin
      @(negedge clk); #1; g++;
    end
    check($sformatf("accept_wait_c%0d", k), 32'(g < 200), 32'd1);
    @(negedge clk);
    iv[k] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!ov[k] && lat < 200);
  endtask

  // Full transaction with out_ready high, checking result, flag, latency and return to IDLE
  task automatic do_op(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] exp;
    exp = model(op, a, b);
    out_ready = 1'b1;
    issue_wait(k, op, a, b, lat);
    check($sformatf("lat_c%0d", k), 32'(lat), 32'(nchunk[k]));
    check($sformatf("valid_c%0d", k), 32'(ov[k]), 32'd1);
    check($sformatf("res_c%0d", k), res[k], exp);
    check($sformatf("zero_c%0d", k), 32'(zr[k]), 32'(exp == 32'h0));
    @(negedge clk); #1;
    check($sformatf("idle_valid_c%0d", k), 32'(ov[k]), 32'd0);
    check($sformatf("idle_ready_c%0d", k), 32'(ir[k]), 32'd1);
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_ready_c%0d", k), 32'(ir[k]), 32'd1);
      check($sformatf("rst_valid_c%0d", k), 32'(ov[k]), 32'd0);
      check($sformatf("rst_res_c%0d", k), res[k], 32'h0);
      check($sformatf("rst_zero_c%0d", k), 32'(zr[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases on the CHUNK = 8 instance
    do_op(1, 2'd1, 32'hF0F0_0000, 32'h0F0F_1234);
    check("or_value", res[1], 32'hFFFF_1234);
    do_op(1, 2'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    check("and_zero", 32'(zr[1]), 32'd1);
    do_op(1, 2'd3, 32'hFFFF_0000, 32'h0F0F_0F0F);
    check("andn_value", res[1], 32'hF0F0_0000);

    // Back-pressure: result held, next request blocked until the handshake
    out_ready = 1'b0;
    issue_wait(1, 2'd2, 32'hFFFF_FFFF, 32'h1234_5678, lat);
    check("xor_lat", 32'(lat), 32'd4);
    in_op = 2'd1; in_a = 32'h0000_00A5; in_b = 32'h0000_005A; iv[1] = 1'b1;
    repeat (4) begin
      #1;
      check("hold_valid", 32'(ov[1]), 32'd1);
      check("hold_res", res[1], 32'hEDCB_A987);
      check("hold_zero", 32'(zr[1]), 32'd0);
      check("hold_ready", 32'(ir[1]), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("hs_ready_before", 32'(ir[1]), 32'd0);
    @(negedge clk); #1;
    check("hs_valid_after", 32'(ov[1]), 32'd0);
    check("hs_ready_after", 32'(ir[1]), 32'd1);
    do_op(1, 2'd1, 32'h0000_00A5, 32'h0000_005A);

    // Reset pulse during the second RUN cycle
    in_op = 2'd1; in_a = 32'hFFFF_FFFF; in_b = 32'h0; iv[1] = 1'b1;
    @(negedge clk);
    iv[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_res", res[1], 32'h0);
    check("mrst_zero", 32'(zr[1]), 32'd0);
    check("mrst_valid", 32'(ov[1]), 32'd0);
    check("mrst_ready", 32'(ir[1]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1, 2'd1, 32'h0000_0001, 32'h0000_0002);
    check("post_rst_value", res[1], 32'h0000_0003);

    // Flush in DONE together with out_ready and a new request
    out_ready = 1'b0;
    issue_wait(1, 2'd2, 32'h0000_FFFF, 32'h0000_0F0F, lat);
    check("flush_pre_valid", 32'(ov[1]), 32'd1);
    out_ready = 1'b1; flush = 1'b1; iv[1] = 1'b1;
    in_a = 32'h1111_1111; in_b = 32'h2222_2222;
    #1;
    check("flush_ready", 32'(ir[1]), 32'd0);
    @(negedge clk);
    flush = 1'b0; iv[1] = 1'b0;
    #1;
    check("flush_valid", 32'(ov[1]), 32'd0);
    check("flush_idle", 32'(ir[1]), 32'd1);
    repeat (6) @(negedge clk);
    check("flush_no_accept", 32'(ov[1]), 32'd0);

    // Random sweep across all chunk sizes
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        logic [1:0]  op;
        logic [31:0] a, b;
        op = 2'($urandom_range(0, 3));
        a = $urandom;
        b = (i % 5 == 0) ? a : $urandom;
        do_op(k, op, a, b);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
